// File: rtl/alu_seq_pkg.sv
// Shared constants for alu_seq: opcodes, FSM state encoding, default operand width.
// The iterative multiply opcode is only live when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier, one multiplier bit per step; product_o already includes the current step.
// Latency DATA_W steps after load; no backpressure, steps only when step_i is high.
module alu_seq_mul #(
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    input  logic                  step_i,
    output logic [2*DATA_W-1:0]   product_o,
    output logic                  last_o
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;

    // Exposing the post-step sum lets the caller capture the final product on the last step edge.
    assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o    = (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= product_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with start/busy/done handshake; flags_write_o = done_o & captured flags_en.
// Latency 1 for single-cycle ops, DATA_W+1 for MUL (ALU_SEQ_MUL_EN); start ignored while in MUL.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              flags_en_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              overflow_o,
    output logic              flags_write_o
);
    localparam int MSB = DATA_W - 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q;
    logic              carry_q, overflow_q, flags_en_q;
    logic              accept, is_mul;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c, alu_v;
    logic [DATA_W:0]   sum;

    assign accept = start_i && (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef ALU_SEQ_MUL_EN
    logic                mul_step, mul_last;
    logic [2*DATA_W-1:0] mul_prod;

    assign is_mul   = (op_i == OP_MUL);
    assign mul_step = (state_q == ST_MUL);

    alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (accept && is_mul),
        .a_i       (a_i),
        .b_i       (b_i),
        .step_i    (mul_step),
        .product_o (mul_prod),
        .last_o    (mul_last)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        sum   = '0;
        case (op_i)
            OP_ADD: begin
                sum   = {1'b0, a_i} + {1'b0, b_i};
                alu_r = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
                alu_v = (a_i[MSB] == b_i[MSB]) && (alu_r[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                alu_r = a_i - b_i;
                alu_c = (a_i < b_i);
                alu_v = (a_i[MSB] != b_i[MSB]) && (alu_r[MSB] != a_i[MSB]);
            end
            OP_AND: alu_r = a_i & b_i;
            OP_OR:  alu_r = a_i | b_i;
            OP_XOR: alu_r = a_i ^ b_i;
            OP_NOT: alu_r = ~a_i;
            OP_SHL: begin
                alu_r = a_i << 1;
                alu_c = a_i[MSB];
            end
            OP_SHR: begin
                alu_r = a_i >> 1;
                alu_c = a_i[0];
            end
            OP_INC: begin
                sum   = {1'b0, a_i} + {{DATA_W{1'b0}}, 1'b1};
                alu_r = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
                alu_v = (a_i == {1'b0, {(DATA_W-1){1'b1}}});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = is_mul ? ST_MUL : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: if (mul_last) state_d = ST_DONE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q == ST_MUL);
        done_o        = (state_q == ST_DONE);
        flags_write_o = (state_q == ST_DONE) && flags_en_q;
    end

    // MUL keeps the previous result visible until its own DONE cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            flags_en_q <= 1'b0;
        end else begin
            if (accept) begin
                flags_en_q <= flags_en_i;
            end
            if (accept && !is_mul) begin
                result_q   <= alu_r;
                carry_q    <= alu_c;
                overflow_q <= alu_v;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (mul_step && mul_last) begin
                result_q   <= mul_prod[DATA_W-1:0];
                carry_q    <= |mul_prod[2*DATA_W-1:DATA_W];
                overflow_q <= 1'b0;
            end
`endif
        end
    end

    assign result_o   = result_q;
    assign carry_o    = carry_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single-cycle ops plus hand sequences for
// back-to-back accept, MUL / reserved opcode 9, and reset mid-operation.
module tb_alu_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       flags_en;
    logic       busy, done, carry, overflow, flags_write;
    logic [7:0] result;

    int total = 0;
    int bad   = 0;
    logic busy_seen = 1'b0;

    alu_seq dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .flags_en_i    (flags_en),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
        .carry_o       (carry),
        .overflow_o    (overflow),
        .flags_write_o (flags_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (busy === 1'b1) busy_seen = 1'b1;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       fen;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic d, input logic [7:0] r,
                           input logic c, input logic v, input logic fw, input logic bz);
        chk({name, ".done"}, 32'(done), 32'(d));
        chk({name, ".result"}, 32'(result), 32'(r));
        chk({name, ".carry"}, 32'(carry), 32'(c));
        chk({name, ".ovf"}, 32'(overflow), 32'(v));
        chk({name, ".fw"}, 32'(flags_write), 32'(fw));
        chk({name, ".busy"}, 32'(busy), 32'(bz));
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic fen);
        start    = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        flags_en = fen;
    endtask

    initial begin
        vecs[0]  = '{"add_ovf",  4'd0,  8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[1]  = '{"sub_brw",  4'd1,  8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
        vecs[2]  = '{"add_cry",  4'd0,  8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{"sub_ovf",  4'd1,  8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[4]  = '{"and",      4'd2,  8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0};
        vecs[5]  = '{"or",       4'd3,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{"xor",      4'd4,  8'hFF, 8'h0F, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[7]  = '{"not",      4'd5,  8'h55, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0};
        vecs[8]  = '{"shl",      4'd6,  8'h81, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[9]  = '{"shr",      4'd7,  8'h81, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0};
        vecs[10] = '{"inc_ovf",  4'd8,  8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[11] = '{"inc_wrap", 4'd8,  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{"rsv12",    4'd12, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00; flags_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table: accept at one edge, outputs valid just after it, then a quiet cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fen);
            @(posedge clk);
            #1 start = 1'b0;
            chk_out(vecs[i].name, 1'b1, vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].fen, 1'b0);
            @(posedge clk);
            #1 chk_out({vecs[i].name, ".hold"}, 1'b0, vecs[i].r, vecs[i].c, vecs[i].v, 1'b0, 1'b0);
        end

        // Back-to-back accepts: done high on consecutive cycles.
        @(negedge clk) issue(4'd6, 8'h81, 8'h00, 1'b1);
        @(posedge clk);
        #1 chk_out("b2b_shl", 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(4'd8, 8'hFF, 8'h00, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        chk_out("b2b_inc", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 chk_out("b2b_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
        // Set a known prior result, then MUL 0x10*0x20 = 0x0200; ADD issued mid-busy is ignored.
        @(negedge clk) issue(4'd4, 8'h5A, 8'h00, 1'b0);
        @(posedge clk);
        #1 issue(4'd9, 8'h10, 8'h20, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk_out($sformatf("mul_busy%0d", i), 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 2) issue(4'd0, 8'h01, 8'h01, 1'b0);
            if (i == 3) start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk_out("mul_done", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 chk_out("mul_after", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-MUL.
        @(negedge clk) issue(4'd9, 8'hFF, 8'hFF, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
`else
        // Opcode 9 without the multiplier is reserved, single-cycle.
        @(negedge clk) issue(4'd9, 8'h10, 8'h20, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        chk_out("op9_rsv", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 chk_out("op9_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_never", 32'(busy_seen), 32'd0);

        // Reset right after a result with nonzero flags.
        @(negedge clk) issue(4'd0, 8'h7F, 8'h01, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
`endif
        @(negedge clk) rst_n = 1'b0;
        #1 chk_out("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        begin
            logic done_seen;
            done_seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1 if (done !== 1'b0 || flags_write !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
            end
            chk("rst_quiet", 32'(done_seen), 32'd0);
        end
        chk_out("rst_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Handshake still works after reset.
        @(negedge clk) issue(4'd1, 8'h10, 8'h20, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        chk_out("post_rst_sub", 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
